seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Display-side consumer of the 16-bit packed BCD angle count (4 digits, digit3 in [15:12] … digit0 in [3:0]) produced by the rotation counter in the rot_clk domain.
- Resynchronises the count into the fpga_clk domain and captures it only when stable, once per scan frame, so no digit tears.
- Time-multiplexes the four digits onto a common-anode 7-segment module.
- Sits between the angle counter and the board's 7-seg pins.

Parameters:
SCAN_DIV, 100000, fpga_clk cycles each digit is lit; legal range >= 2.

Ports:
fpga_clk  input  1  system clock; all logic on rising edge
sys_init_n  input  1  asynchronous active-low reset
bcd_int  input  16  packed BCD count, asynchronous to fpga_clk
disp_en  input  1  1 = drive display, 0 = blank all anodes and segments
seg_n  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
an_n  output  4  digit anode select, active-low, bit k = digit k
frame_tick  output  1  one-cycle pulse at each frame wrap (digit3 -> digit0)

Behaviour:
- Clock and reset: one clock, fpga_clk. Reset is asynchronous, active-low, on sys_init_n. Assertion takes effect immediately, including mid-scan.
- Reset values: sync stages s1/s2/s3 = 0; disp_reg = 0; prescaler = 0; idx = 0; an_n = 4'b1111; seg_n = 7'h7F; frame_tick = 0.
- Synchroniser: s1 <= bcd_int, s2 <= s1, s3 <= s2 every cycle. stable = (s2 == s3).
- Prescaler: counts 0..SCAN_DIV-1 and wraps to 0. At terminal count, idx advances 0->1->2->3->0.
- Frame wrap: occurs at terminal count with idx == 3. On that edge:
  - frame_tick = 1 for exactly one cycle.
  - disp_reg <= s3 if stable; otherwise disp_reg keeps its value.
  - Capture happens only at frame wrap, so the first capture is 4*SCAN_DIV cycles after reset release.
- Output registers, updated every cycle, one cycle latency from idx/disp_reg:
  - an_n = ~(4'b0001 << idx) when disp_en = 1.
  - seg_n = ~decode(disp_reg[4*idx+3 : 4*idx]).
- Decode table, active-high {g..a}: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibbles 10..15 are invalid BCD and decode to a dash: 40, i.e. seg_n = 7'h3F.
- disp_en = 0: an_n = 4'b1111 and seg_n = 7'h7F on the next edge. Prescaler, idx, capture and frame_tick keep running. Re-enable resumes at the current idx, with no restart.
- The display is never driven from s1/s2/s3 directly; only disp_reg reaches the decoder.

Optional Feature:
SEG7_BLANK_EN
- Defined: leading-zero blanking. Digit k (k = 3, 2, 1) is blanked (seg_n = 7'h7F, an_n still selects it) when disp_reg digits 3..k are all 0. Digit0 is never blanked.
- Undefined: every digit is decoded, including leading zeros.

Test Plan:
1. SCAN_DIV=4, reset, bcd_int=16'h1234 held.
   -> frame_tick pulses at cycle 16 after release.
   -> In the next frame: an_n=1110/seg_n=7'h19 (4), 1101/7'h30 (3), 1011/7'h24 (2), 0111/7'h79 (1), each for 4 cycles.
2. bcd_int=16'h9A00.
   -> digit2 slot seg_n=7'h3F (dash); digit3 seg_n=7'h10 (9); digits 1/0 seg_n=7'h40 (0).
3. Load 16'h1234, then toggle bcd_int between 16'h0000 and 16'h5555 every cycle across a frame wrap.
   -> disp_reg stays 16'h1234; the displayed digits are unchanged.
4. SEG7_BLANK_EN defined, bcd_int=16'h0040.
   -> digit3 and digit2 seg_n=7'h7F; digit1 seg_n=7'h19; digit0 seg_n=7'h40.
   -> Same stimulus without the macro: digits 3 and 2 show seg_n=7'h40.
5. disp_en dropped mid-digit2.
   -> Next edge: an_n=4'b1111, seg_n=7'h7F; frame_tick still pulses on schedule.
   -> Re-assert: the display resumes at the current idx.
6. sys_init_n asserted mid-digit1.
   -> an_n=4'b1111, seg_n=7'h7F, frame_tick=0 immediately, without waiting for a clock edge.
   -> After release, the scan restarts at idx 0 showing 0 until the first capture.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver fed by an asynchronous packed-BCD count.
// Optional build macro SEG7_BLANK_EN enables leading-zero blanking of digits 3..1.
module seg7_scan_driver #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        fpga_clk,
  input  logic        sys_init_n,
  input  logic [15:0] bcd_int,
  input  logic        disp_en,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] TERM_CNT = PW'(SCAN_DIV - 1);

  logic [15:0]   s1_r;
  logic [15:0]   s2_r;
  logic [15:0]   s3_r;
  logic [15:0]   disp_r;
  logic [PW-1:0] presc_r;
  logic [1:0]    idx_r;
  logic [6:0]    seg_n_r;
  logic [3:0]    an_n_r;
  logic          frame_tick_r;

  logic          term_s;
  logic          wrap_s;
  logic          stable_s;
  logic [PW-1:0] presc_next_s;
  logic [1:0]    idx_next_s;
  logic [15:0]   disp_next_s;
  logic [3:0]    nib_s;
  logic          blank_s;
  logic [6:0]    seg_n_next_s;
  logic [3:0]    an_n_next_s;

  // Active-high {g..a} pattern; non-BCD nibbles show a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h40;
    endcase
    return seg;
  endfunction

`ifdef SEG7_BLANK_EN
  // A digit is a leading zero when it and every more significant digit are 0.
  function automatic logic lead_zero(input logic [15:0] val, input logic [1:0] idx);
    logic z;
    case (idx)
      2'd3:    z = (val[15:12] == 4'd0);
      2'd2:    z = (val[15:8]  == 8'd0);
      2'd1:    z = (val[15:4]  == 12'd0);
      default: z = 1'b0;
    endcase
    return z;
  endfunction
`endif

  // Timebase, digit select and stable-only capture at frame wrap.
  always_comb begin
    term_s       = (presc_r == TERM_CNT);
    wrap_s       = term_s && (idx_r == 2'd3);
    stable_s     = (s2_r == s3_r);
    presc_next_s = presc_r + PW'(1'b1);
    idx_next_s   = idx_r;
    disp_next_s  = disp_r;
    if (term_s) begin
      presc_next_s = '0;
      idx_next_s   = idx_r + 2'd1;
    end else begin
      presc_next_s = presc_r + PW'(1'b1);
    end
    if (wrap_s && stable_s) begin
      disp_next_s = s3_r;
    end else begin
      disp_next_s = disp_r;
    end
  end

  // Segment/anode values for the currently selected digit.
  always_comb begin
    nib_s        = 4'd0;
    blank_s      = 1'b0;
    seg_n_next_s = 7'h7F;
    an_n_next_s  = 4'b1111;
    case (idx_r)
      2'd0:    nib_s = disp_r[3:0];
      2'd1:    nib_s = disp_r[7:4];
      2'd2:    nib_s = disp_r[11:8];
      2'd3:    nib_s = disp_r[15:12];
      default: nib_s = 4'd0;
    endcase
`ifdef SEG7_BLANK_EN
    blank_s = lead_zero(disp_r, idx_r);
`else
    blank_s = 1'b0;
`endif
    if (disp_en) begin
      an_n_next_s = ~(4'b0001 << idx_r);
      if (blank_s) begin
        seg_n_next_s = 7'h7F;
      end else begin
        seg_n_next_s = ~bcd_to_seg(nib_s);
      end
    end else begin
      an_n_next_s  = 4'b1111;
      seg_n_next_s = 7'h7F;
    end
  end

  // State and registered outputs.
  always_ff @(posedge fpga_clk or negedge sys_init_n) begin
    if (!sys_init_n) begin
      s1_r         <= 16'h0000;
      s2_r         <= 16'h0000;
      s3_r         <= 16'h0000;
      disp_r       <= 16'h0000;
      presc_r      <= '0;
      idx_r        <= 2'd0;
      seg_n_r      <= 7'h7F;
      an_n_r       <= 4'b1111;
      frame_tick_r <= 1'b0;
    end else begin
      s1_r         <= bcd_int;
      s2_r         <= s1_r;
      s3_r         <= s2_r;
      disp_r       <= disp_next_s;
      presc_r      <= presc_next_s;
      idx_r        <= idx_next_s;
      seg_n_r      <= seg_n_next_s;
      an_n_r       <= an_n_next_s;
      frame_tick_r <= wrap_s;
    end
  end

  assign seg_n      = seg_n_r;
  assign an_n       = an_n_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (SCAN_DIV=4): directed table, corner sequences, random frames.
module tb_seg7_scan_driver;

  localparam int SD = 4;

  logic        fpga_clk;
  logic        sys_init_n;
  logic [15:0] bcd_int;
  logic        disp_en;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(.SCAN_DIV(SD)) dut (
    .fpga_clk  (fpga_clk),
    .sys_init_n(sys_init_n),
    .bcd_int   (bcd_int),
    .disp_en   (disp_en),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .frame_tick(frame_tick)
  );

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  typedef struct {
    logic [15:0]       bcd;
    logic [15:0]       en_vec;
    logic [3:0][6:0]   exp_seg;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: active-high pattern from the digit table, inverted for the pins.
  function automatic logic [6:0] seg_model(input logic [15:0] v, input int k);
    int nib;
    logic [6:0] hi;
    nib = (int'(v) / (1 << (4 * k))) % 16;
`ifdef SEG7_BLANK_EN
    if (k > 0 && (int'(v) / (1 << (4 * k))) == 0) return 7'h7F;
`endif
    case (nib)
      0: hi = 7'h3F; 1: hi = 7'h06; 2: hi = 7'h5B; 3: hi = 7'h4F; 4: hi = 7'h66;
      5: hi = 7'h6D; 6: hi = 7'h7D; 7: hi = 7'h07; 8: hi = 7'h7F; 9: hi = 7'h6F;
      default: hi = 7'h40;
    endcase
    return ~hi;
  endfunction

  function automatic logic [3:0][6:0] exp_of(input logic [15:0] v);
    logic [3:0][6:0] e;
    for (int k = 0; k < 4; k++) e[k] = seg_model(v, k);
    return e;
  endfunction

  // One full frame starting just after a frame tick; ends on the next tick.
  task automatic run_frame(input logic [3:0][6:0] exp, input logic [15:0] en_vec, input bit toggle);
    logic [3:0] a_exp;
    int k;
    for (int i = 0; i < 4 * SD; i++) begin
      disp_en = en_vec[i];
      if (toggle) bcd_int = i[0] ? 16'h5555 : 16'h0000;
      @(negedge fpga_clk);
      k = i / SD;
      if (en_vec[i]) begin
        a_exp = ~(4'b0001 << k);
        chk("an_n", {12'h000, an_n}, {12'h000, a_exp});
        chk("seg_n", {9'h000, seg_n}, {9'h000, exp[k]});
      end else begin
        chk("an_n_blank", {12'h000, an_n}, 16'h000F);
        chk("seg_n_blank", {9'h000, seg_n}, 16'h007F);
      end
      chk("frame_tick", {15'h0000, frame_tick}, {15'h0000, (i == 4 * SD - 1)});
    end
  endtask

  logic [3:0][6:0] prev_exp;
  logic [15:0]     prev_v;
  logic [15:0]     v;

  initial begin
    tbl[0] = '{bcd: 16'h1234, en_vec: 16'hFFFF, exp_seg: {7'h79, 7'h24, 7'h30, 7'h19}};
    tbl[1] = '{bcd: 16'h9A00, en_vec: 16'hFFFF, exp_seg: {7'h10, 7'h3F, 7'h40, 7'h40}};
`ifdef SEG7_BLANK_EN
    tbl[2] = '{bcd: 16'h0040, en_vec: 16'hFFFF, exp_seg: {7'h7F, 7'h7F, 7'h19, 7'h40}};
`else
    tbl[2] = '{bcd: 16'h0040, en_vec: 16'hFFFF, exp_seg: {7'h40, 7'h40, 7'h19, 7'h40}};
`endif
    tbl[3] = '{bcd: 16'h1234, en_vec: 16'hF9FF, exp_seg: {7'h79, 7'h24, 7'h30, 7'h19}};

    sys_init_n = 1'b0;
    disp_en    = 1'b1;
    bcd_int    = 16'h1234;
    #12;
    chk("rst_an_n", {12'h000, an_n}, 16'h000F);
    chk("rst_seg_n", {9'h000, seg_n}, 16'h007F);
    chk("rst_frame_tick", {15'h0000, frame_tick}, 16'h0000);
    @(negedge fpga_clk);
    sys_init_n = 1'b1;

    // First frame shows zeros; tick at cycle 16 captures 1234.
    run_frame(exp_of(16'h0000), 16'hFFFF, 1'b0);

    prev_exp = tbl[0].exp_seg;
    for (int r = 0; r < 4; r++) begin
      bcd_int = tbl[r].bcd;
      run_frame(prev_exp, tbl[r].en_vec, 1'b0);
      prev_exp = tbl[r].exp_seg;
    end

    // Unstable input across the wrap: capture is skipped.
    run_frame(prev_exp, 16'hFFFF, 1'b1);
    bcd_int = 16'h5555;
    run_frame(prev_exp, 16'hFFFF, 1'b0);

    // Asynchronous reset while digit1 is lit.
    disp_en = 1'b1;
    bcd_int = 16'h0708;
    for (int i = 0; i < SD + 1; i++) @(negedge fpga_clk);
    chk("pre_rst_an_n", {12'h000, an_n}, 16'h000D);
    chk("pre_rst_seg_n", {9'h000, seg_n}, {9'h000, seg_model(16'h5555, 1)});
    #1 sys_init_n = 1'b0;
    #1;
    chk("async_rst_an_n", {12'h000, an_n}, 16'h000F);
    chk("async_rst_seg_n", {9'h000, seg_n}, 16'h007F);
    chk("async_rst_tick", {15'h0000, frame_tick}, 16'h0000);
    @(negedge fpga_clk);
    sys_init_n = 1'b1;
    run_frame(exp_of(16'h0000), 16'hFFFF, 1'b0);
    prev_v = 16'h0708;

    for (int n = 0; n < 24; n++) begin
      v = 16'($urandom);
      bcd_int = v;
      run_frame(exp_of(prev_v), 16'($urandom | $urandom | $urandom), 1'b0);
      prev_v = v;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
